serial_frame_deserializer: RTL and testbench
============================================

// Module: serial_frame_deserializer
// PURPOSE
//  Receive side of the shift-register serial link: collects an MSB-first bit
//  stream into WIDTH-bit words and presents each word on a valid/ready
//  parallel port. Sits downstream of a serial-out (MSB-first, shift-left)
//  transmitter. Has a one-word output buffer, so the next frame can shift in
//  while the previous word is waiting to be taken.
// PARAMETERS
//  WIDTH   4   bits per frame / parallel word width (legal range: WIDTH >= 2)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  s_valid    in   1      s_in is sampled on a clk edge only when s_valid=1
//  s_start    in   1      marks the first bit of a frame; qualified by s_valid
//  s_in       in   1      serial data, MSB first
//  p_data     out  WIDTH  received word
//  p_valid    out  1      p_data holds an untaken word
//  p_ready    in   1      consumer accepts p_data when p_valid=1 and p_ready=1
//  busy       out  1      a frame is partially received (state SHIFT)
//  overrun    out  1      1-cycle pulse: completed word dropped because buffer full
//  frame_err  out  1      1-cycle pulse: s_start seen mid-frame, partial frame discarded
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; shift reg=0; bit count=0; p_data=0;
//   p_valid=0; busy=0; overrun=0; frame_err=0. Every output is registered.
//  Bit acceptance: a bit is accepted on an edge where s_valid=1. s_valid=0
//   cycles are gaps; they change nothing.
//  FSM (2 states):
//   IDLE : s_valid & s_start -> shift reg LSB=s_in, cnt=1, go to SHIFT.
//          s_valid & !s_start -> bit ignored, stay in IDLE (no error).
//   SHIFT: s_valid & !s_start -> sr<={sr[WIDTH-2:0],s_in}, cnt<=cnt+1.
//          s_valid & s_start  -> resync: frame_err=1 for one cycle; partial
//            frame discarded; this bit becomes bit 1 of a new frame (cnt=1).
//            Resync takes priority even when this would be the WIDTH-th bit.
//          WIDTH-th bit accepted -> word complete, go to IDLE, cnt=0.
//  Word completion (on the edge that accepts the last bit):
//   - Buffer free, or being drained on the same edge (p_valid & p_ready):
//     p_data<={sr[WIDTH-2:0],s_in}, p_valid=1. Latency is 0 cycles after the
//     last-bit edge: p_valid is high from that edge.
//   - Buffer full and p_ready=0: the word is dropped; overrun=1 for one cycle;
//     p_data and p_valid do not change.
//  Output handshake: while p_valid=1 and p_ready=0, p_data is stable. On
//   p_valid & p_ready with no new completion, p_valid<=0 and p_data holds its
//   last value.
//  Back-to-back: a new frame may start (s_valid & s_start) on the cycle right
//   after completion. A continuous stream of frames at one bit per clock
//   loses nothing when p_ready=1.
//  busy = (state==SHIFT).
//  Count width: $clog2(WIDTH)+1 bits. The count never exceeds WIDTH.
//  rst_n asserted mid-frame or with p_valid=1: everything clears immediately
//   and the word is lost. After release, bits are ignored until s_start.
// TESTING
//  1 Reset, then bits 1,0,1,1 (s_start on first), p_ready=0 -> p_valid=1 from
//    4th-bit edge, p_data=4'b1011 held stable; p_ready=1 for 1 clk -> p_valid=0.
//  2 Same frame with s_valid=0 gaps of 0..3 cycles between bits -> p_data=4'b1011,
//    exactly one p_valid rise; busy=1 from bit 1 to bit 4.
//  3 Frames 1011 then 0110 back-to-back at 1 bit/clk, p_ready=1 -> words 4'hB
//    then 4'h6 in order, overrun never asserted.
//  4 p_ready=0: frame 1011, then frame 0110 -> overrun pulses on 0110 completion,
//    p_data stays 4'hB; repeat with p_ready=1 on the completion edge -> p_data=4'h6,
//    no overrun.
//  5 Bits 1,0 then s_start with bits 1,1,0,0 -> frame_err pulse on the 3rd bit,
//    p_data=4'b1100; bits without s_start while in IDLE are ignored.
//  6 rst_n=0 mid-frame (cnt=2) and again with p_valid=1 -> all outputs 0 without
//    waiting for clk; the next s_start frame 0101 is received correctly.

Source files
------------

// File: rtl/serial_frame_deserializer_if.sv
// Parallel word port of the serial frame deserializer: valid/ready handshake.
// The master is the word producer (the deserializer); the slave consumes words.
interface serial_frame_deserializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] p_data;
    logic             p_valid;
    logic             p_ready;

    modport master (
        output p_data,
        output p_valid,
        input  p_ready
    );

    modport slave (
        input  p_data,
        input  p_valid,
        output p_ready
    );
endinterface

// File: rtl/serial_frame_deserializer.sv
// Collects an MSB-first serial bit stream into WIDTH-bit words and offers each
// word on a one-deep valid/ready output buffer.
module serial_frame_deserializer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    input  logic                          s_start,
    input  logic                          s_in,
    serial_frame_deserializer_if.master   p,
    output logic                          busy,
    output logic                          overrun,
    output logic                          frame_err
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] p_data_q, p_data_d;
    logic             p_valid_q, p_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_bit;

    assign shifted   = {sr_q[WIDTH-2:0], s_in};
    assign first_bit = {{(WIDTH-1){1'b0}}, s_in};

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        p_data_d    = p_data_q;
        p_valid_d   = p_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = 1'b0;

        if (p_valid_q && p.p_ready) begin
            p_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // Bits without a start marker are line noise while idle.
                if (s_valid && s_start) begin
                    sr_d    = first_bit;
                    cnt_d   = CntW'(1);
                    state_d = StShift;
                end
            end
            StShift: begin
                if (s_valid) begin
                    if (s_start) begin
                        // Resync wins even over what would be the final bit.
                        frame_err_d = 1'b1;
                        sr_d        = first_bit;
                        cnt_d       = CntW'(1);
                    end else begin
                        sr_d = shifted;
                        if (cnt_q == LastCnt) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                            // A same-edge drain frees the buffer for this word.
                            if (!p_valid_q || p.p_ready) begin
                                p_data_d  = shifted;
                                p_valid_d = 1'b1;
                            end else begin
                                overrun_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            cnt_q       <= '0;
            p_data_q    <= '0;
            p_valid_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            p_data_q    <= p_data_d;
            p_valid_q   <= p_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign p.p_data  = p_data_q;
    assign p.p_valid = p_valid_q;
    assign busy      = (state_q == StShift);
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer: each task drives one scenario
// and checks outputs against hand-computed values.
module tb_serial_frame_deserializer;

    localparam int unsigned WIDTH = 4;

    logic clk;
    logic rst_n;
    logic s_valid;
    logic s_start;
    logic s_in;
    logic busy;
    logic overrun;
    logic frame_err;

    int total;
    int bad;
    int rises;
    int ov_seen;
    int fe_seen;
    logic pv_prev;

    serial_frame_deserializer_if #(.WIDTH(WIDTH)) pif ();

    serial_frame_deserializer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_start   (s_start),
        .s_in      (s_in),
        .p         (pif),
        .busy      (busy),
        .overrun   (overrun),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (pif.p_valid && !pv_prev) rises++;
        pv_prev = pif.p_valid;
        if (overrun) ov_seen++;
        if (frame_err) fe_seen++;
    endtask

    task automatic send_bit(input logic st, input logic b);
        s_valid = 1'b1;
        s_start = st;
        s_in    = b;
        tick();
        s_valid = 1'b0;
        s_start = 1'b0;
        s_in    = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] w);
        send_bit(1'b1, w[3]);
        send_bit(1'b0, w[2]);
        send_bit(1'b0, w[1]);
        send_bit(1'b0, w[0]);
    endtask

    task automatic drain();
        pif.p_ready = 1'b1;
        tick();
        pif.p_ready = 1'b0;
        total++;
        if (pif.p_valid !== 1'b0) begin
            $display("FAIL drain_pvalid: got %b want 0", pif.p_valid);
            bad++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (pif.p_valid !== 1'b0) begin
            $display("FAIL reset_pvalid: got %b want 0", pif.p_valid); bad++;
        end
        total++;
        if (pif.p_data !== 4'h0) begin
            $display("FAIL reset_pdata: got %h want 0", pif.p_data); bad++;
        end
        total++;
        if (busy !== 1'b0) begin
            $display("FAIL reset_busy: got %b want 0", busy); bad++;
        end
        total++;
        if (overrun !== 1'b0 || frame_err !== 1'b0) begin
            $display("FAIL reset_pulses: got ov=%b fe=%b want 0 0", overrun, frame_err); bad++;
        end
        #3;
        rst_n = 1'b1;
        tick();
        pv_prev = pif.p_valid;
    endtask

    task automatic test_basic();
        pif.p_ready = 1'b0;
        send_bit(1'b1, 1'b1);
        total++;
        if (busy !== 1'b1) begin
            $display("FAIL basic_busy_bit1: got %b want 1", busy); bad++;
        end
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        total++;
        if (pif.p_valid !== 1'b0) begin
            $display("FAIL basic_early_valid: got %b want 0", pif.p_valid); bad++;
        end
        send_bit(1'b0, 1'b1);
        total++;
        if (pif.p_valid !== 1'b1 || pif.p_data !== 4'hB) begin
            $display("FAIL basic_word: got v=%b d=%h want v=1 d=b", pif.p_valid, pif.p_data);
            bad++;
        end
        total++;
        if (busy !== 1'b0) begin
            $display("FAIL basic_busy_done: got %b want 0", busy); bad++;
        end
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (pif.p_valid !== 1'b1 || pif.p_data !== 4'hB) begin
            $display("FAIL basic_hold: got v=%b d=%h want v=1 d=b", pif.p_valid, pif.p_data);
            bad++;
        end
        drain();
        total++;
        if (pif.p_data !== 4'hB) begin
            $display("FAIL basic_data_kept: got %h want b", pif.p_data); bad++;
        end
    endtask

    task automatic test_gaps();
        logic [3:0] w;
        w = 4'b1011;
        pif.p_ready = 1'b0;
        pv_prev = pif.p_valid;
        rises = 0;
        for (int i = 0; i < 4; i++) begin
            send_bit(i == 0, w[3-i]);
            if (i < 3) begin
                for (int g = 0; g < i + 1; g++) begin
                    tick();
                    total++;
                    if (busy !== 1'b1) begin
                        $display("FAIL gaps_busy: bit %0d gap %0d got %b want 1", i, g, busy);
                        bad++;
                    end
                end
            end
        end
        total++;
        if (pif.p_valid !== 1'b1 || pif.p_data !== 4'hB || busy !== 1'b0) begin
            $display("FAIL gaps_word: got v=%b d=%h busy=%b want v=1 d=b busy=0",
                     pif.p_valid, pif.p_data, busy);
            bad++;
        end
        tick();
        tick();
        total++;
        if (rises !== 1) begin
            $display("FAIL gaps_rises: got %0d want 1", rises); bad++;
        end
        drain();
    endtask

    task automatic test_back_to_back();
        pif.p_ready = 1'b1;
        ov_seen = 0;
        send_frame(4'hB);
        total++;
        if (pif.p_valid !== 1'b1 || pif.p_data !== 4'hB) begin
            $display("FAIL b2b_first: got v=%b d=%h want v=1 d=b", pif.p_valid, pif.p_data);
            bad++;
        end
        send_frame(4'h6);
        total++;
        if (pif.p_valid !== 1'b1 || pif.p_data !== 4'h6) begin
            $display("FAIL b2b_second: got v=%b d=%h want v=1 d=6", pif.p_valid, pif.p_data);
            bad++;
        end
        tick();
        total++;
        if (pif.p_valid !== 1'b0) begin
            $display("FAIL b2b_drained: got %b want 0", pif.p_valid); bad++;
        end
        total++;
        if (ov_seen !== 0) begin
            $display("FAIL b2b_overrun: got %0d pulses want 0", ov_seen); bad++;
        end
        pif.p_ready = 1'b0;
    endtask

    task automatic test_overrun();
        pif.p_ready = 1'b0;
        send_frame(4'hB);
        send_frame(4'h6);
        total++;
        if (overrun !== 1'b1) begin
            $display("FAIL ovr_pulse: got %b want 1", overrun); bad++;
        end
        total++;
        if (pif.p_valid !== 1'b1 || pif.p_data !== 4'hB) begin
            $display("FAIL ovr_kept: got v=%b d=%h want v=1 d=b", pif.p_valid, pif.p_data);
            bad++;
        end
        tick();
        total++;
        if (overrun !== 1'b0) begin
            $display("FAIL ovr_one_cycle: got %b want 0", overrun); bad++;
        end
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        pif.p_ready = 1'b1;
        send_bit(1'b0, 1'b0);
        pif.p_ready = 1'b0;
        total++;
        if (overrun !== 1'b0 || pif.p_valid !== 1'b1 || pif.p_data !== 4'h6) begin
            $display("FAIL ovr_same_edge: got ov=%b v=%b d=%h want ov=0 v=1 d=6",
                     overrun, pif.p_valid, pif.p_data);
            bad++;
        end
        drain();
    endtask

    task automatic test_frame_err();
        pif.p_ready = 1'b0;
        fe_seen = 0;
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        total++;
        if (busy !== 1'b0 || pif.p_valid !== 1'b0) begin
            $display("FAIL ferr_idle_ignored: got busy=%b v=%b want 0 0", busy, pif.p_valid);
            bad++;
        end
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        total++;
        if (frame_err !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL ferr_pulse: got fe=%b busy=%b want 1 1", frame_err, busy); bad++;
        end
        send_bit(1'b0, 1'b1);
        total++;
        if (frame_err !== 1'b0) begin
            $display("FAIL ferr_one_cycle: got %b want 0", frame_err); bad++;
        end
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        total++;
        if (pif.p_valid !== 1'b1 || pif.p_data !== 4'hC || fe_seen !== 1) begin
            $display("FAIL ferr_word: got v=%b d=%h fe_pulses=%0d want v=1 d=c 1",
                     pif.p_valid, pif.p_data, fe_seen);
            bad++;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        pif.p_ready = 1'b0;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            $display("FAIL rst_mid_busy: got %b want 0", busy); bad++;
        end
        #1;
        rst_n = 1'b1;
        tick();
        send_frame(4'hF);
        total++;
        if (pif.p_valid !== 1'b1 || pif.p_data !== 4'hF) begin
            $display("FAIL rst_setup_word: got v=%b d=%h want v=1 d=f", pif.p_valid, pif.p_data);
            bad++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (pif.p_valid !== 1'b0 || pif.p_data !== 4'h0 || busy !== 1'b0) begin
            $display("FAIL rst_full_clear: got v=%b d=%h busy=%b want 0 0 0",
                     pif.p_valid, pif.p_data, busy);
            bad++;
        end
        #1;
        rst_n = 1'b1;
        tick();
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b0);
        total++;
        if (busy !== 1'b0) begin
            $display("FAIL rst_ignore_nostart: got busy=%b want 0", busy); bad++;
        end
        send_frame(4'h5);
        total++;
        if (pif.p_valid !== 1'b1 || pif.p_data !== 4'h5) begin
            $display("FAIL rst_next_word: got v=%b d=%h want v=1 d=5", pif.p_valid, pif.p_data);
            bad++;
        end
        drain();
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rises       = 0;
        ov_seen     = 0;
        fe_seen     = 0;
        pv_prev     = 1'b0;
        s_valid     = 1'b0;
        s_start     = 1'b0;
        s_in        = 1'b0;
        pif.p_ready = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
